// File: rtl/mld_code_pkg.sv
// Shared constants and types for the multi-step majority-logic decoding chain.
// Holds the generator polynomials, the encoder phase type and a counter-width helper.
package mld_code_pkg;

    localparam logic [8:0]  G_15_7 = 9'h1D1;
    localparam logic [10:0] G_15_5 = 11'h537;

    typedef enum logic {
        PH_MSG = 1'b0,
        PH_PAR = 1'b1
    } phase_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cyclic_encoder_param.sv
// Systematic serial encoder for binary cyclic (N,K) codes: forwards K message bits,
// then appends the N-K parity bits of m(x)*x^(N-K) mod g(x). Valid/ready on both sides.
module cyclic_encoder_param
    import mld_code_pkg::*;
#(
    parameter int           N   = 15,
    parameter int           K   = 7,
    parameter logic [N-K:0] GEN = G_15_7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    localparam int R  = N - K;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] R_LAST = CW'(R - 1);

    if (R < 1 || GEN[R] != 1'b1 || GEN[0] != 1'b1) begin : g_bad_gen
        $error("cyclic_encoder_param: GEN must have degree R>=1 with GEN[R]=1 and GEN[0]=1");
    end

    // Handshake rule (both ports): a bit moves on a rising edge where valid && ready;
    // the sender holds valid and data stable until that edge, the receiver may toggle
    // ready freely, and in_ready never looks at in_valid.

    phase_e          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [R-1:0]    rem_q, rem_d, rem_msg;
    logic            out_valid_q, out_valid_d;
    logic            out_bit_q, out_bit_d;
    logic            out_last_q, out_last_d;
    logic            slot_free;
    logic            accept;
    logic            fb;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (phase_q == PH_MSG) && slot_free && !reset && !clear;
    assign accept    = in_valid && in_ready;
    assign fb        = in_bit ^ rem_q[R-1];

    // LFSR division step: shift the remainder and fold in g(x) when the feedback is set.
    for (genvar i = 0; i < R; i++) begin : g_rem
        if (i == 0) begin : g_lsb
            assign rem_msg[i] = fb & GEN[i];
        end else begin : g_upper
            assign rem_msg[i] = rem_q[i-1] ^ (fb & GEN[i]);
        end
    end

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;

        if (clear) begin
            phase_d     = PH_MSG;
            cnt_d       = '0;
            rem_d       = '0;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
        end else if (phase_q == PH_MSG) begin
            if (accept) begin
                rem_d       = rem_msg;
                out_valid_d = 1'b1;
                out_bit_d   = in_bit;
                out_last_d  = 1'b0;
                if (cnt_q == K_LAST) begin
                    phase_d = PH_PAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (slot_free) begin
                out_valid_d = 1'b0;
            end
        end else if (slot_free) begin
            out_valid_d = 1'b1;
            out_bit_d   = rem_q[R-1];
            out_last_d  = (cnt_q == R_LAST);
            if (cnt_q == R_LAST) begin
                // Leave the remainder clean so the next codeword can start without a gap.
                phase_d = PH_MSG;
                cnt_d   = '0;
                rem_d   = '0;
            end else begin
                rem_d = rem_q << 1;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_MSG;
            cnt_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = (phase_q == PH_PAR) || (cnt_q != '0) || out_valid_q;

endmodule

// File: tb/tb_cyclic_encoder_param.sv
// Bench for cyclic_encoder_param: a (15,7) instance and a (15,5) instance, with
// expected codeword bits queued at issue time and popped by per-instance monitors.
module tb_cyclic_encoder_param;
    import mld_code_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic clear_a, clear_b;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic in_valid_a, in_ready_a, in_bit_a, out_valid_a, out_ready_a, out_bit_a, out_last_a, busy_a;
    logic in_valid_b, in_ready_b, in_bit_b, out_valid_b, out_ready_b, out_bit_b, out_last_b, busy_b;

    cyclic_encoder_param #(.N(15), .K(7), .GEN(G_15_7)) dut_a (
        .clk(clk), .reset(reset), .clear(clear_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bit(in_bit_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bit(out_bit_a),
        .out_last(out_last_a), .busy(busy_a)
    );

    cyclic_encoder_param #(.N(15), .K(5), .GEN(G_15_5)) dut_b (
        .clk(clk), .reset(reset), .clear(clear_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bit(in_bit_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bit(out_bit_b),
        .out_last(out_last_b), .busy(busy_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_a[$];   // {last, bit}
    logic [1:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: polynomial long division of m(x)*x^r by g(x); bit d = coeff of x^d.
    function automatic logic [14:0] ref_codeword(input int k, input logic [10:0] g, input logic [14:0] msg);
        int r;
        logic [14:0] p;
        r = 15 - k;
        p = msg << r;
        for (int d = 14; d >= r; d--)
            if (p[d]) p = p ^ (15'(g) << (d - r));
        return (msg << r) | p;
    endfunction

    // ---------------- monitors ----------------
    logic       stall_a = 1'b0;
    logic [1:0] held_a;
    int         valid_cnt_a = 0;
    int         first_v_a = -1;
    int         last_v_a = -1;

    always @(negedge clk) begin
        logic [1:0] e;
        if (stall_a)
            check("stall_hold_a", {out_valid_a, out_last_a, out_bit_a}, {1'b1, held_a});
        stall_a = out_valid_a && !out_ready_a && !reset && !clear_a;
        held_a  = {out_last_a, out_bit_a};
        if (out_valid_a) begin
            valid_cnt_a++;
            if (first_v_a < 0) first_v_a = cyc;
            last_v_a = cyc;
        end
        if (out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_a_extra @%0t: got bit %0b with nothing expected", $time, out_bit_a);
            end else begin
                e = exp_a.pop_front();
                check("out_a", {30'd0, out_last_a, out_bit_a}, {30'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_b_extra @%0t: got bit %0b with nothing expected", $time, out_bit_b);
            end else begin
                e = exp_b.pop_front();
                check("out_b", {30'd0, out_last_b, out_bit_b}, {30'd0, e});
            end
        end
    end

    // ---------------- random sink ----------------
    logic rand_ready = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready_a = 1'($urandom_range(0, 1));
    end

    // ---------------- drivers ----------------
    task automatic drive_bit_a(input logic b);
        int t = 0;
        in_valid_a = 1'b1;
        in_bit_a   = b;
        forever begin
            @(negedge clk);
            if (in_ready_a) break;
            if (++t > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_a_timeout @%0t: in_ready stuck at 0", $time);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
    endtask

    task automatic drive_bit_b(input logic b);
        int t = 0;
        in_valid_b = 1'b1;
        in_bit_b   = b;
        forever begin
            @(negedge clk);
            if (in_ready_b) break;
            if (++t > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_b_timeout @%0t: in_ready stuck at 0", $time);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
    endtask

    task automatic send_a(input logic [14:0] msg, input logic [14:0] cw, input int gap_max);
        for (int i = 14; i >= 0; i--) exp_a.push_back({i == 0, cw[i]});
        for (int i = 6; i >= 0; i--) begin
            if (gap_max > 0)
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            drive_bit_a(msg[i]);
        end
    endtask

    task automatic send_b(input logic [14:0] msg, input logic [14:0] cw);
        for (int i = 14; i >= 0; i--) exp_b.push_back({i == 0, cw[i]});
        for (int i = 4; i >= 0; i--) drive_bit_b(msg[i]);
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < limit) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_a_empty", exp_a.size(), 0);
        check("drain_b_empty", exp_b.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [14:0] m;
        reset = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
        in_valid_a = 1'b0; in_bit_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_bit_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_bit", out_bit_a, 0);
        check("rst_out_last", out_last_a, 0);
        check("rst_busy", busy_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready_a", in_ready_a, 1);
        check("post_rst_in_ready_b", in_ready_b, 1);
        @(posedge clk);
        #1;

        // Directed (15,7) codewords, the first two back to back.
        valid_cnt_a = 0;
        first_v_a   = -1;
        send_a(15'h40, 15'b100000011101000, 0);
        send_a(15'h01, 15'b000000111010001, 0);
        drain(200);
        check("b2b_valid_cycles", valid_cnt_a, 30);
        check("b2b_span", last_v_a - first_v_a + 1, 30);
        send_a(15'h41, 15'b100000100111001, 0);
        send_a(15'h00, 15'b000000000000000, 0);
        drain(200);

        // (15,5) instance: directed then random at full rate.
        send_b(15'h01, 15'b000010100110111);
        for (int n = 0; n < 30; n++) begin
            m = 15'($urandom_range(0, 31));
            send_b(m, ref_codeword(5, G_15_5, m));
        end
        drain(200);

        // Random back-pressure and input gaps.
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            m = 15'($urandom_range(0, 127));
            send_a(m, ref_codeword(7, 11'(G_15_7), m), 2);
        end
        drain(5000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Clear after 4 message bits, colliding with a valid input bit.
        exp_a.push_back(2'b01); drive_bit_a(1'b1);
        exp_a.push_back(2'b00); drive_bit_a(1'b0);
        exp_a.push_back(2'b01); drive_bit_a(1'b1);
        exp_a.push_back(2'b01); drive_bit_a(1'b1);
        in_valid_a = 1'b1;
        in_bit_a   = 1'b1;
        clear_a    = 1'b1;
        @(negedge clk);
        check("clear_in_ready", in_ready_a, 0);
        @(posedge clk);
        #1;
        clear_a    = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        check("clear_out_valid", out_valid_a, 0);
        check("clear_busy", busy_a, 0);
        @(posedge clk);
        #1;
        send_a(15'h01, 15'b000000111010001, 0);
        drain(200);

        // Reset during a stalled parity phase.
        send_a(15'h40, 15'b100000011101000, 0);
        @(posedge clk);
        #1;
        out_ready_a = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("pre_rst_out_valid", out_valid_a, 1);
        check("pre_rst_busy", busy_a, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        check("par_rst_out_valid", out_valid_a, 0);
        check("par_rst_busy", busy_a, 0);
        check("par_rst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        send_a(15'h41, 15'b100000100111001, 0);
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog @%0t: simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
